// File: rtl/spc_pcx_pipe_buf_pkg.sv
// Shared PCX header: packet width, buffer defaults and the credit-counter
// width helper used by the core-to-PCX pipe buffer.
package spc_pcx_pipe_buf_pkg;

    // PCX packet width.
    localparam int PCX_WIDTH  = 124;

    // Number of PCX destinations (one-hot request/grant width).
    localparam int PCX_NDEST  = 5;

    // Register stages per direction (legal 0..2).
    localparam int PCX_PIPE   = 1;

    // Queue entries per destination inside the PCX (legal 1..7).
    localparam int PCX_QDEPTH = 2;

    // Width of a counter that must hold every value from 0 to qdepth.
    function automatic int pcx_cnt_w(input int qdepth);
        return $clog2(qdepth + 1);
    endfunction

endpackage : spc_pcx_pipe_buf_pkg

// File: rtl/spc_pcx_pipe_buf_credit_ctr.sv
// Per-destination outstanding-request counter with saturating bounds and
// sticky overflow/underflow flags.
module spc_pcx_credit_ctr
    import spc_pcx_pipe_buf_pkg::*;
#(
    parameter int QDEPTH = PCX_QDEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,           // request leaving toward the PCX
    input  logic dec,           // grant arriving from the PCX
    input  logic err_clr,
    output logic credit_avail,
    output logic err_ovf,
    output logic err_unf
);

    localparam int             CW   = pcx_cnt_w(QDEPTH);
    localparam logic [CW-1:0]  QMAX = CW'(QDEPTH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ovf_hit;
    logic          unf_hit;

    // Next count: a request and grant together cancel, bounds never wrap.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        cnt_nxt = cnt;
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        unique case ({inc, dec})
            2'b10: begin
                if (cnt == QMAX) ovf_hit = 1'b1;
                else             cnt_nxt = cnt + 1'b1;
            end
            2'b01: begin
                if (cnt == '0)   unf_hit = 1'b1;
                else             cnt_nxt = cnt - 1'b1;
            end
            default: ;
        endcase
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

    // Sticky error flags; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= ovf_hit | (err_ovf & ~err_clr);
            err_unf <= unf_hit | (err_unf & ~err_clr);
        end
    end

    // Credit comes straight off the counter register, not the next-state logic.
    assign credit_avail = (cnt < QMAX);

endmodule : spc_pcx_credit_ctr

// File: rtl/spc_pcx_pipe_buf_dly.sv
// Generic fixed-latency delay line: N unconditional register stages, or a
// plain wire when N is 0. Every stage, data included, clears on reset.
module spc_pcx_dly #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (N == 0) begin : g_wire
            // Zero-latency path; clock and reset have no role here.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = din;
        end else begin : g_reg
            logic [W-1:0] stage [N];

            // Shift the input through N stages every cycle; no stall exists.
            always_ff @(posedge clk or posedge rst) begin
                // NOTE: the stage array is a handful of flops, not a RAM, so
                // resetting it is cheap and keeps stale packets off the bus.
                if (rst) begin
                    for (int i = 0; i < N; i++) stage[i] <= '0;
                end else begin
                    // NOTE: non-blocking assignments make every stage sample
                    // its predecessor's old value, giving a true shift.
                    stage[0] <= din;
                    for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[N-1];
        end
    endgenerate

endmodule : spc_pcx_dly

// File: rtl/spc_pcx_pipe_buf.sv
// Core-to-PCX pipe buffer: retimes request/atomic/data toward the PCX and
// grant back toward the core, and tracks PCX queue credits per destination.
module spc_pcx_pipe_buf
    import spc_pcx_pipe_buf_pkg::*;
#(
    parameter int NDEST  = PCX_NDEST,
    parameter int DW     = PCX_WIDTH,
    parameter int PIPE   = PCX_PIPE,
    parameter int QDEPTH = PCX_QDEPTH
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic [NDEST-1:0] spc_pcx_req_pq_buf,
    input  logic             spc_pcx_atom_pq_buf,
    input  logic [DW-1:0]    spc_pcx_data_pa_buf,
    input  logic [NDEST-1:0] pcx_spc_grant_px,
    input  logic             err_clr,
    output logic [NDEST-1:0] spc_pcx_req_pq,
    output logic             spc_pcx_atom_pq,
    output logic [DW-1:0]    spc_pcx_data_pa,
    output logic [NDEST-1:0] pcx_spc_grant_px_buf,
    output logic [NDEST-1:0] pcx_credit_avail,
    output logic [NDEST-1:0] pcx_err_ovf,
    output logic [NDEST-1:0] pcx_err_unf
);

    // Request and atomic marker share timing, so they ride one delay line.
    // Data uses an equal-length line, so its one-cycle lag is preserved.
    spc_pcx_dly #(.W(NDEST + 1), .N(PIPE)) u_req_dly (
        .clk  (rclk),
        .rst  (reset),
        .din  ({spc_pcx_atom_pq_buf, spc_pcx_req_pq_buf}),
        .dout ({spc_pcx_atom_pq, spc_pcx_req_pq})
    );

    spc_pcx_dly #(.W(DW), .N(PIPE)) u_data_dly (
        .clk  (rclk),
        .rst  (reset),
        .din  (spc_pcx_data_pa_buf),
        .dout (spc_pcx_data_pa)
    );

    spc_pcx_dly #(.W(NDEST), .N(PIPE)) u_grant_dly (
        .clk  (rclk),
        .rst  (reset),
        .din  (pcx_spc_grant_px),
        .dout (pcx_spc_grant_px_buf)
    );

    // Credits count requests as the PCX sees them (output side) and are
    // returned by grants as the PCX issues them (input side).
    generate
        for (genvar d = 0; d < NDEST; d++) begin : g_dest
            spc_pcx_credit_ctr #(.QDEPTH(QDEPTH)) u_ctr (
                .clk          (rclk),
                .rst          (reset),
                .inc          (spc_pcx_req_pq[d]),
                .dec          (pcx_spc_grant_px[d]),
                .err_clr      (err_clr),
                .credit_avail (pcx_credit_avail[d]),
                .err_ovf      (pcx_err_ovf[d]),
                .err_unf      (pcx_err_unf[d])
            );
        end
    endgenerate

endmodule : spc_pcx_pipe_buf

// File: doc/spc_pcx_pipe_buf.md
SPC_PCX_PIPE_BUF -- requirements
Module: spc_pcx_pipe_buf

Interface
REQ-001: Parameters SHALL be, one per line (name, default, meaning):
  NDEST, 5, number of PCX destinations (one-hot req/grant width).
  DW, PCX_WIDTH, packet data width.
  PIPE, 1, register stages per direction (legal 0..2).
  QDEPTH, 2, PCX queue entries per destination (legal 1..7).
REQ-002: Ports SHALL be, one per line (name, direction, width, meaning):
  rclk  in  1  sole clock.
  reset  in  1  asynchronous, active-high reset.
  spc_pcx_req_pq_buf  in  NDEST  core request, one bit per destination.
  spc_pcx_atom_pq_buf  in  1  core atomic marker (first of a two-packet pair).
  spc_pcx_data_pa_buf  in  DW  core packet, driven one cycle after its req.
  pcx_spc_grant_px  in  NDEST  PCX grant per destination.
  err_clr  in  1  clears sticky error flags.
  spc_pcx_req_pq  out  NDEST  request to PCX.
  spc_pcx_atom_pq  out  1  atomic marker to PCX.
  spc_pcx_data_pa  out  DW  packet to PCX.
  pcx_spc_grant_px_buf  out  NDEST  grant to core.
  pcx_credit_avail  out  NDEST  destination has a free queue entry.
  pcx_err_ovf  out  NDEST  sticky: request with no free entry.
  pcx_err_unf  out  NDEST  sticky: grant with nothing outstanding.

Function
REQ-003: req, atom and data SHALL each pass through exactly PIPE stages; the one-cycle req-to-data offset SHALL be preserved at the outputs.
REQ-004: pcx_spc_grant_px SHALL pass through exactly PIPE stages to pcx_spc_grant_px_buf.
REQ-005: With PIPE=0, all four paths SHALL be purely combinational with no added latency.
REQ-006: Pipeline stages SHALL be unconditional; there is no stall or backpressure.
REQ-007: Per destination d, a counter cnt[d] of width clog2(QDEPTH+1) SHALL track outstanding requests.
REQ-008: cnt[d] SHALL increment on spc_pcx_req_pq[d] (output side) and decrement on pcx_spc_grant_px[d] (input side).
REQ-009: Simultaneous req and grant on the same d SHALL leave cnt[d] unchanged, with no error, even at cnt=0 or cnt=QDEPTH.
REQ-010: Request alone at cnt[d]=QDEPTH SHALL hold cnt[d] at QDEPTH and set pcx_err_ovf[d].
REQ-011: Grant alone at cnt[d]=0 SHALL hold cnt[d] at 0 and set pcx_err_unf[d].
REQ-012: The counter SHALL never wrap in either direction.
REQ-013: Each cycle of an atomic pair SHALL count as one request; atom SHALL NOT alter counting.
REQ-014: pcx_credit_avail[d] SHALL equal (cnt[d] < QDEPTH) and SHALL be driven directly from the counter register.
REQ-015: Error flags SHALL be sticky until err_clr.
REQ-016: err_clr SHALL clear all error flags on the next edge; a new error in the same cycle as err_clr SHALL win, so the flag reads 1.
REQ-017: Multiple req bits in one cycle (multicast) SHALL update each addressed counter independently.

Reset
REQ-018: reset SHALL asynchronously clear all pipeline registers (including data), all counters and all error flags.
REQ-019: During reset, every registered output SHALL be 0 and pcx_credit_avail SHALL be all ones.
REQ-020: Deassertion mid-traffic SHALL discard in-flight pipeline contents; counting SHALL restart from 0.
REQ-021: With PIPE=0, the data outputs SHALL follow their inputs even during reset.

Structure
REQ-022: The NDEST, QDEPTH and PIPE defaults and the counter-width expression SHALL live in the shared PCX header alongside PCX_WIDTH.
REQ-023: The per-destination counter and its error flags SHALL be one sub-module, spc_pcx_credit_ctr, instantiated NDEST times by a generate loop.
REQ-024: A generic delay line SHALL be reused for all pipeline stages; no new package types SHALL be added.

Verification
REQ-025: PIPE=1; req=5'b00100 at cycle 0, data=D at cycle 1 -> spc_pcx_req_pq=5'b00100 at cycle 1, spc_pcx_data_pa=D at cycle 2, cnt[2]=1.
REQ-026: QDEPTH=2; three requests to d0 with no grant -> pcx_credit_avail[0]=0 after the second request; pcx_err_ovf[0]=1 after the third; cnt[0] stays 2.
REQ-027: Grant to d3 at cnt=0 -> pcx_err_unf[3]=1; err_clr pulse -> 0; err_clr coincident with a new underflow -> remains 1.
REQ-028: cnt[1]=2 with req and grant on d1 in the same cycle -> cnt[1]=2, no error, credit_avail[1]=0.
REQ-029: Atomic pair to d4 (atom=1 then req again next cycle) -> cnt[4]=2; two grants -> 0.
REQ-030: reset asserted mid-stream with PIPE=2 -> outputs 0 immediately; after release, first output req appears exactly 2 cycles after first input req; all errors 0.
